// File: rtl/tx_pkg.sv
// ---------------------------------------------------------------------------
// tx_pkg -- shared definitions for the store-and-forward packet transmitter.
//   FLIT_W / DEPTH : default flit width and packet buffer depth
//   PTR_W          : buffer pointer width (a packet never exceeds 8 flits)
//   LEN_MSB/LEN_LSB: position of the body-length field inside the header flit
//   state_e        : transmitter state encoding
// ---------------------------------------------------------------------------
package tx_pkg;

    localparam int FLIT_W  = 8;
    localparam int DEPTH   = 8;
    localparam int PTR_W   = 3;
    localparam int LEN_MSB = 2;
    localparam int LEN_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_e;

endpackage

// File: rtl/tx_buffer.sv
// ---------------------------------------------------------------------------
// tx_buffer -- packet storage, DEPTH x FLIT_W registers.
// Ports:
//   clk          : clock, writes on rising edge
//   we/waddr/wdata : synchronous write port
//   raddr/rdata  : asynchronous read port
// Contents are not reset; a packet is always written before it is read.
// ---------------------------------------------------------------------------
module tx_buffer #(
    parameter int FLIT_W = tx_pkg::FLIT_W,
    parameter int DEPTH  = tx_pkg::DEPTH,
    parameter int AW     = tx_pkg::PTR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [FLIT_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [FLIT_W-1:0] rdata
);

    logic [FLIT_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/tx.sv
// ---------------------------------------------------------------------------
// tx -- store-and-forward packet transmitter.
// A packet is a header flit (bits [2:0] = number of body flits) followed by
// 0..7 body flits. The whole packet is loaded from the upstream req/ack port,
// then replayed on the downstream channel req/ack port.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_req/in_flit/in_ack : upstream flit input (in_ack low only while sending)
//   ch_req/ch_flit/ch_ack : downstream channel (ch_flit is 0 when ch_req low)
//   busy                : a packet is being loaded or sent
//   pkt_count           : packets sent, wraps at 256 (only with TX_PKT_COUNT_EN)
// Optional feature macro: TX_PKT_COUNT_EN
//
// state | meaning
// IDLE  | waiting for a header flit
// LOAD  | storing body flits until LEN have arrived
// SEND  | presenting stored flits on the channel
// ---------------------------------------------------------------------------
module tx #(
    parameter int FLIT_W = tx_pkg::FLIT_W,
    parameter int DEPTH  = tx_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_req,
    input  logic [FLIT_W-1:0] in_flit,
    output logic              in_ack,
    output logic              ch_req,
    output logic [FLIT_W-1:0] ch_flit,
    input  logic              ch_ack,
    output logic              busy
`ifdef TX_PKT_COUNT_EN
    ,
    output logic [7:0]        pkt_count
`endif
);

    import tx_pkg::*;

    state_e            state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  len_q;
    logic              ch_req_q;
    logic              busy_q;

    logic              in_xfer;
    logic              ch_xfer;
    logic              last_out;
    logic [PTR_W-1:0]  in_len;
    logic              buf_we;
    logic [PTR_W-1:0]  buf_waddr;
    logic [FLIT_W-1:0] buf_rdata;

    assign in_ack    = (state_q != SEND);
    assign in_xfer   = in_req & in_ack;
    assign ch_xfer   = ch_req_q & ch_ack;
    assign last_out  = ch_xfer & (rd_ptr_q == len_q);
    assign in_len    = in_flit[LEN_MSB:LEN_LSB];

    // Header always lands in entry 0; wr_ptr only matters during LOAD.
    assign buf_we    = in_xfer & ~reset;
    assign buf_waddr = (state_q == IDLE) ? '0 : wr_ptr_q;

    tx_buffer #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_buffer (
        .clk   (clk),
        .we    (buf_we),
        .waddr (buf_waddr),
        .wdata (in_flit),
        .raddr (rd_ptr_q),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            ch_req_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_xfer) begin
                        len_q  <= in_len;
                        busy_q <= 1'b1;
                        if (in_len == '0) begin
                            state_q  <= SEND;
                            rd_ptr_q <= '0;
                            ch_req_q <= 1'b1;
                        end else begin
                            state_q  <= LOAD;
                            wr_ptr_q <= PTR_W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (in_xfer) begin
                        if (wr_ptr_q == len_q) begin
                            state_q  <= SEND;
                            wr_ptr_q <= '0;
                            rd_ptr_q <= '0;
                            ch_req_q <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        end
                    end
                end
                SEND: begin
                    if (last_out) begin
                        state_q  <= IDLE;
                        rd_ptr_q <= '0;
                        ch_req_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (ch_xfer) begin
                        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    ch_req_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ch_req  = ch_req_q;
    assign busy    = busy_q;
    // Channel data is forced to zero outside SEND so stale buffer contents never leak.
    assign ch_flit = ch_req_q ? buf_rdata : '0;

`ifdef TX_PKT_COUNT_EN
    logic [7:0] pkt_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_count_q <= '0;
        end else if (last_out) begin
            pkt_count_q <= pkt_count_q + 8'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_tx.sv
`timescale 1ns/1ps
module tb_tx;

    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_req;
    logic [FW-1:0] in_flit;
    logic          in_ack;
    logic          ch_req;
    logic [FW-1:0] ch_flit;
    logic          ch_ack;
    logic          busy;
`ifdef TX_PKT_COUNT_EN
    logic [7:0]    pkt_count;
`endif

    always #5 clk = ~clk;

    tx #(.FLIT_W(FW), .DEPTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_req  (in_req),
        .in_flit (in_flit),
        .in_ack  (in_ack),
        .ch_req  (ch_req),
        .ch_flit (ch_flit),
        .ch_ack  (ch_ack),
        .busy    (busy)
`ifdef TX_PKT_COUNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Packet-level model: flits accepted upstream are queued in order; a packet
    // is "stored" (plen_q non-empty) from the cycle after its last flit arrives
    // until the cycle after its last flit leaves on the channel.
    logic [7:0] exp_q [$];
    int         plen_q [$];
    int         in_cnt = 0;
    int         in_len = 0;
    int         out_idx = 0;
    int         cnt_model = 0;
    bit         chk_rst = 1'b0;
    bit         hold = 1'b0;
    logic [7:0] hold_flit;
    bit         ack_rand = 1'b0;

    initial begin
        logic [7:0] e;
        bit sending;
        forever begin
            @(negedge clk);
            sending = (plen_q.size() != 0);
            if (chk_rst) begin
                chk("rst_ch_req", ch_req, 0);
                chk("rst_busy", busy, 0);
                chk("rst_in_ack", in_ack, 1);
            end
            if (hold) begin
                chk("hold_ch_req", ch_req, 1);
                chk("hold_ch_flit", ch_flit, hold_flit);
            end
            chk("ch_req", ch_req, sending);
            chk("in_ack", in_ack, !sending);
            chk("busy", busy, sending || (in_cnt != 0));
            if (!ch_req) chk("idle_ch_flit_zero", ch_flit, 0);
`ifdef TX_PKT_COUNT_EN
            chk("pkt_count", pkt_count, cnt_model % 256);
`endif
            chk_rst = 1'b0;
            hold    = 1'b0;
            if (reset) begin
                exp_q.delete();
                plen_q.delete();
                in_cnt    = 0;
                out_idx   = 0;
                cnt_model = 0;
                chk_rst   = 1'b1;
            end else begin
                if (ch_req && ch_ack) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_ch_flit");
                    end else begin
                        e = exp_q.pop_front();
                        chk("ch_flit", ch_flit, e);
                    end
                    if (plen_q.size() != 0) begin
                        if (out_idx == plen_q[0]) begin
                            void'(plen_q.pop_front());
                            out_idx = 0;
                            cnt_model++;
                        end else begin
                            out_idx++;
                        end
                    end
                end else if (ch_req) begin
                    hold      = 1'b1;
                    hold_flit = ch_flit;
                end
                if (in_req && in_ack) begin
                    if (in_cnt == 0) in_len = int'(in_flit[2:0]);
                    exp_q.push_back(in_flit);
                    in_cnt++;
                    if (in_cnt == in_len + 1) begin
                        plen_q.push_back(in_len);
                        in_cnt = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_rand) ch_ack = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic put(input logic [7:0] f);
        int n;
        n = 0;
        in_req  = 1'b1;
        in_flit = f;
        @(negedge clk);
        while (!in_ack && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ack) fail_now("in_ack_timeout");
        @(posedge clk);
        #1;
        in_req  = 1'b0;
        in_flit = 8'($urandom);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ch_req) && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= 500) fail_now("drain_timeout");
        idle_cycles(2);
    endtask

    initial begin
        logic [7:0] h;
        int len;

        reset   = 1'b1;
        in_req  = 1'b1;
        in_flit = 8'hA0;
        ch_ack  = 1'b1;
        idle_cycles(3);
        reset  = 1'b0;
        in_req = 1'b0;
        idle_cycles(1);

        // single-flit packet
        put(8'hA0);
        drain();

        // full 8-flit packet
        put(8'h07);
        for (int i = 1; i <= 7; i++) put(8'(8'h11 * i));
        drain();

        // downstream backpressure
        ch_ack = 1'b0;
        put(8'h02);
        put(8'h5A);
        put(8'hC3);
        idle_cycles(5);
        ch_ack = 1'b1;
        drain();

        // upstream gaps
        put(8'h13);
        for (int i = 0; i < 3; i++) begin
            idle_cycles(1);
            put(8'(8'h90 + i));
        end
        drain();

        // reset in the middle of SEND, after two of five flits
        ch_ack = 1'b0;
        put(8'h04);
        for (int i = 0; i < 4; i++) put(8'(8'hE0 + i));
        ch_ack = 1'b1;
        idle_cycles(2);
        ch_ack = 1'b0;
        reset  = 1'b1;
        idle_cycles(1);
        reset  = 1'b0;
        ch_ack = 1'b1;
        put(8'h01);
        put(8'hBE);
        drain();

        // back-to-back one-flit packets
        for (int i = 0; i < 4; i++) begin
            h = 8'($urandom);
            h[2:0] = 3'd0;
            put(h);
        end
        drain();

        // randomized traffic with random backpressure and gaps
        ack_rand = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = int'($urandom_range(0, 7));
            h = 8'($urandom);
            h[2:0] = 3'(len);
            put(h);
            for (int b = 0; b < len; b++) begin
                idle_cycles(int'($urandom_range(0, 2)));
                put(8'($urandom));
            end
        end
        ack_rand = 1'b0;
        ch_ack   = 1'b1;
        drain();

`ifdef TX_PKT_COUNT_EN
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        for (int p = 0; p < 257; p++) begin
            h = 8'($urandom);
            h[2:0] = 3'd0;
            put(h);
        end
        drain();
        chk("pkt_count_wrap", pkt_count, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
